// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered operands, eight operations
// (including a W-cycle shift-add multiply), registered flags and a
// tri-state result bus.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  input  logic         start,
  input  logic         Fi,
  input  logic         Eo,
  output logic [W-1:0] bus,
  output logic         busy,
  output logic         done,
  output logic         ZF,
  output logic         CF,
  output logic         NF,
  output logic         VF
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL} state_t;

  state_t          state, next_state;
  logic            load, finish;
  logic [W-1:0]    a_r, b_r;
  logic [2:0]      op_r;
  logic            fi_r;
  logic [2*W-1:0]  acc, acc_next;
  logic [W-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    result;
  logic [W:0]      sum_add, sum_sub;
  logic [W-1:0]    res_val;
  logic            cf_val, vf_val;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: accept start only in IDLE, finish after one EXEC cycle or the last multiply step
  always_comb begin
    next_state = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = (op == OP_MUL) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: begin
        finish     = 1'b1;
        next_state = ST_IDLE;
      end
      ST_MUL: begin
        if (cnt == LAST) begin
          finish     = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operation result and carry/overflow; in MUL the value reflects the accumulator after this step
  always_comb begin
    sum_add  = {1'b0, a_r} + {1'b0, b_r};
    sum_sub  = {1'b0, a_r} - {1'b0, b_r};
    acc_next = acc + (mplier[0] ? ({{W{1'b0}}, a_r} << cnt) : {2*W{1'b0}});
    res_val  = '0;
    cf_val   = 1'b0;
    vf_val   = 1'b0;
    if (state == ST_MUL) begin
      res_val = acc_next[W-1:0];
      cf_val  = |acc_next[2*W-1:W];
    end else begin
      case (op_r)
        OP_ADD: begin
          res_val = sum_add[W-1:0];
          cf_val  = sum_add[W];
          vf_val  = (a_r[W-1] == b_r[W-1]) && (sum_add[W-1] != a_r[W-1]);
        end
        OP_SUB: begin
          res_val = sum_sub[W-1:0];
          cf_val  = sum_sub[W];
          vf_val  = (a_r[W-1] != b_r[W-1]) && (sum_sub[W-1] != a_r[W-1]);
        end
        OP_AND: res_val = a_r & b_r;
        OP_OR:  res_val = a_r | b_r;
        OP_XOR: res_val = a_r ^ b_r;
        OP_SHL: begin
          res_val = {a_r[W-2:0], 1'b0};
          cf_val  = a_r[W-1];
        end
        OP_SHR: begin
          res_val = {1'b0, a_r[W-1:1]};
          cf_val  = a_r[0];
        end
        default: begin
          res_val = '0;
        end
      endcase
    end
  end

  // Datapath: capture operands on accept, step the multiplier, write result and (if enabled) flags on finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      fi_r   <= 1'b0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      ZF     <= 1'b0;
      CF     <= 1'b0;
      NF     <= 1'b0;
      VF     <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        a_r    <= a;
        b_r    <= b;
        op_r   <= op;
        fi_r   <= Fi;
        acc    <= '0;
        mplier <= b;
        cnt    <= '0;
      end else if (state == ST_MUL) begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
      if (finish) begin
        result <= res_val;
        if (fi_r) begin
          ZF <= (res_val == '0);
          CF <= cf_val;
          NF <= res_val[W-1];
          VF <= vf_val;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign bus  = Eo ? result : {W{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq at W=8 and W=16.
module tb_alu_seq;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   lat_seen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] op8 = '0;
  logic       start8 = 1'b0, fi8 = 1'b0, eo8 = 1'b0;
  tri1  [7:0] bus8;
  logic       busy8, done8, zf8, cf8, nf8, vf8;

  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0]  op16 = '0;
  logic        start16 = 1'b0, fi16 = 1'b0, eo16 = 1'b0;
  tri1  [15:0] bus16;
  logic        busy16, done16, zf16, cf16, nf16, vf16;

  alu_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .op(op8), .start(start8),
    .Fi(fi8), .Eo(eo8), .bus(bus8), .busy(busy8), .done(done8),
    .ZF(zf8), .CF(cf8), .NF(nf8), .VF(vf8)
  );

  alu_seq #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .op(op16), .start(start16),
    .Fi(fi16), .Eo(eo16), .bus(bus16), .busy(busy16), .done(done16),
    .ZF(zf16), .CF(cf16), .NF(nf16), .VF(vf16)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one operation on the W=8 unit at a negedge and record what it must produce
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] opv,
                               input logic fiv, input logic [7:0] eres, input logic [3:0] eflags,
                               input int elat, input string tag);
    exp_t e;
    a8 = av; b8 = bv; op8 = opv; fi8 = fiv; start8 = 1'b1;
    e.res = {8'h00, eres}; e.flags = eflags; e.lat = elat; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~av; b8 = ~bv; op8 = ~opv; fi8 = ~fiv;
  endtask

  // Wait (bounded) for done on the W=8 unit; optionally pulse start while it is busy
  task automatic waitDone(input bit poke);
    int n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      if (poke && n == 1) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; op8 = 3'b000; fi8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      n++;
      checkValue("busy_done_exclusive", {15'd0, busy8 & done8}, 16'd0);
    end
    lat_seen = n;
  endtask

  // Pop the oldest expectation and compare result (read through the bus), flags and latency
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkValue("scoreboard_empty", 16'd1, 16'd0);
      return;
    end
    e = sb.pop_front();
    checkValue({e.tag, "_latency"}, 16'(lat_seen), 16'(e.lat));
    checkValue({e.tag, "_flags"}, {12'd0, zf8, cf8, nf8, vf8}, {12'd0, e.flags});
    eo8 = 1'b1;
    #1;
    checkValue({e.tag, "_result"}, {8'h00, bus8}, e.res);
    eo8 = 1'b0;
  endtask

  initial begin
    logic [15:0] rel8;
    rel8 = 16'h00FF;
    $display("[TB] starting alu_seq bench");

    // Reset state
    #3;
    checkValue("rst_busy", {15'd0, busy8}, 16'd0);
    checkValue("rst_done", {15'd0, done8}, 16'd0);
    checkValue("rst_flags", {12'd0, zf8, cf8, nf8, vf8}, 16'd0);
    checkValue("rst_bus_released", {8'h00, bus8}, rel8);
    eo8 = 1'b1;
    #1;
    checkValue("rst_bus_driven", {8'h00, bus8}, 16'h0000);
    eo8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD wrapping to zero, then back-to-back SUBs
    applyStimulus(8'hFF, 8'h01, 3'b000, 1'b1, 8'h00, 4'b1100, 1, "add_ff_01");
    waitDone(1'b0); checkOutput();
    applyStimulus(8'h02, 8'h05, 3'b001, 1'b1, 8'hFD, 4'b0110, 1, "sub_borrow");
    waitDone(1'b0); checkOutput();
    applyStimulus(8'h80, 8'h01, 3'b001, 1'b1, 8'h7F, 4'b0001, 1, "sub_overflow");
    waitDone(1'b0); checkOutput();

    // MUL with high product bits, start pulsed mid-operation
    applyStimulus(8'h10, 8'h11, 3'b111, 1'b1, 8'h10, 4'b0100, 8, "mul_10_11");
    waitDone(1'b1); checkOutput();

    // XOR with flag update disabled keeps the MUL flags
    applyStimulus(8'h5A, 8'h5A, 3'b100, 1'b0, 8'h00, 4'b0100, 1, "xor_nofi");
    waitDone(1'b0); checkOutput();

    // MUL without overflow; bus shows previous result while busy
    applyStimulus(8'h0F, 8'h03, 3'b111, 1'b1, 8'h2D, 4'b0000, 8, "mul_0f_03");
    eo8 = 1'b1;
    #1;
    checkValue("bus_while_busy", {8'h00, bus8}, 16'h0000);
    eo8 = 1'b0;
    waitDone(1'b0); checkOutput();

    // Logic ops and right shift
    applyStimulus(8'hC3, 8'h0F, 3'b010, 1'b1, 8'h03, 4'b0000, 1, "and_op");
    waitDone(1'b0); checkOutput();
    applyStimulus(8'h81, 8'h00, 3'b110, 1'b1, 8'h40, 4'b0100, 1, "shr_op");
    waitDone(1'b0); checkOutput();

    // Asynchronous reset in the middle of a MUL
    applyStimulus(8'hFF, 8'hFF, 3'b111, 1'b1, 8'h00, 4'b0000, 0, "unused");
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    checkValue("mid_mul_busy", {15'd0, busy8}, 16'd1);
    #2;
    rst_n = 1'b0;
    eo8 = 1'b1;
    #1;
    checkValue("abort_busy", {15'd0, busy8}, 16'd0);
    checkValue("abort_done", {15'd0, done8}, 16'd0);
    checkValue("abort_flags", {12'd0, zf8, cf8, nf8, vf8}, 16'd0);
    checkValue("abort_bus", {8'h00, bus8}, 16'h0000);
    eo8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // W=16 SHL
    begin
      exp_t e;
      int n;
      e.res = 16'h0002; e.flags = 4'b0100; e.lat = 1; e.tag = "shl16";
      sb.push_back(e);
      a16 = 16'h8001; b16 = 16'h0000; op16 = 3'b101; fi16 = 1'b1; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0; a16 = 16'h0000;
      n = 0;
      while (done16 !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      e = sb.pop_front();
      checkValue("shl16_latency", 16'(n), 16'(e.lat));
      checkValue("shl16_flags", {12'd0, zf16, cf16, nf16, vf16}, {12'd0, e.flags});
      #1;
      checkValue("shl16_bus_released", bus16, 16'hFFFF);
      eo16 = 1'b1;
      #1;
      checkValue("shl16_bus_result", bus16, e.res);
      eo16 = 1'b0;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the 8-bit combinational adder/subtractor ALU. It registers operands on a start strobe and runs eight operations, including a multi-cycle shift-add multiply. Results and flags are held in registers; the result drives the shared tri-state data bus under the output-enable signal. It sits between the A/B registers and the bus, and its flag outputs feed the control unit's conditional-jump logic.

## Interface
- W, 8, datapath width in bits; legal range W >= 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  3  opcode, sampled with start:
  - 000 ADD, 001 SUB, 010 AND, 011 OR.
  - 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- start  in  1  begin an operation; honoured only in IDLE.
- Fi  in  1  flag-update enable, sampled with start.
- Eo  in  1  bus output enable.
- bus  out  W  result register when Eo=1, high-Z otherwise (combinational on Eo).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the result is written.
- ZF, CF, NF, VF  out  1 each  zero, carry/borrow, negative and signed-overflow flags (registered).

## Operation
- States: IDLE, EXEC, MUL.
- IDLE, start=1 at an edge:
  - capture a, b, op and Fi into internal registers;
  - go to MUL if op=111, otherwise EXEC.
- start in EXEC or MUL is ignored; captured operands are unaffected by later changes on a, b or op.
- EXEC: one cycle. Write the result register, pulse done, return to IDLE.
- MUL: W iterations of shift-add.
  - 2W-bit accumulator; multiplier register shifts right each cycle.
  - Iteration counter is $clog2(W+1) bits.
  - On the last iteration, write the low W bits, pulse done, return to IDLE.
- Arithmetic uses W+1-bit internal sums:
  - ADD: a+b; CF = carry out.
  - SUB: a−b; CF = 1 when a<b unsigned (borrow).
  - ADD/SUB: VF = signed overflow.
  - AND, OR, XOR: CF=0, VF=0.
  - SHL: result = a<<1, zero fill; CF = a[W-1]; VF=0.
  - SHR: result = a>>1 logical; CF = a[0]; VF=0.
  - MUL: result = (a*b)[W-1:0]; CF = 1 when (a*b)[2W-1:W] ≠ 0; VF=0.
- Flags, for all ops:
  - ZF = (result == 0) over all W bits.
  - NF = result[W-1].
- Flag registers update in the same edge as the result, and only if the captured Fi=1. Otherwise they hold their previous values.
- The result register holds its value until the next operation completes. bus may be enabled at any time, including while busy; it then shows the previous result.
- Reset mid-operation: abort immediately, return to IDLE, and apply all reset values.

## Timing
- Reset values:
  - result = 0, ZF=CF=NF=VF = 0;
  - busy = 0, done = 0, state IDLE;
  - bus = high-Z unless Eo=1, in which case it drives 0.
- Edge k samples start=1 in IDLE; busy=1 from edge k.
- Non-MUL: result and flags valid, done=1, busy=0 after edge k+1. Latency 1 cycle.
- MUL: result and flags valid, done=1, busy=0 after edge k+W. Latency W cycles.
- done is high for exactly one cycle. The state is IDLE during that cycle, so start sampled at edge k+2 (non-MUL) is accepted, giving back-to-back issue every 2 cycles.
- busy and done are never high together.

## Test plan
- Reset: assert rst_n=0 mid-MUL (W=8) → busy=0, done=0, all flags 0 and bus=0 with Eo=1, asynchronously and before the next edge.
- ADD, W=8: a=0xFF, b=0x01, Fi=1 → after 1 cycle result 0x00, ZF=1, CF=1, NF=0, VF=0, done pulse of width 1.
- SUB, W=8: a=0x02, b=0x05 → result 0xFD, CF=1, NF=1, ZF=0. Then SUB with a=0x80, b=0x01 → result 0x7F, VF=1.
- MUL, W=8: a=0x10, b=0x11 → busy for 8 cycles, then result 0x10, CF=1. Repeat with a=0x0F, b=0x03 → result 0x2D, CF=0.
- Fi=0 on an XOR with a=b=0x5A → result 0x00, flags unchanged from the prior op. start pulsed while busy during a MUL → ignored, MUL result correct.
- W=16 regression: SHL with a=0x8001 → result 0x0002, CF=1. Bus is high-Z with Eo=0 and 0x0002 with Eo=1.
